fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Time-division arbiter for the single-port 640x480x12 frame buffer. It shares the one memory port between three users: the VGA scan-out reader, a pixel writer (camera/processing pipeline) and a processor read-back port. It generates the 25 MHz pixel enable from CLK100MHZ and guarantees the scan-out one memory access per pixel period. The remaining slots go to the writer and read-back clients, round-robin.

## Interface
Parameters:
- NPIX, 307200: valid frame buffer words; addresses >= NPIX are out of range.
- AW, 19: address width.
- DW, 12: pixel width, RGB444.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz; the only clock.
- rst  in  1  asynchronous, active-low reset.
- pixel_ce  out  1  one-cycle pulse every 4 clocks, in phase 3; VGA pipeline advances on it.
- vga_raddr  in  AW  scan-out address, sampled in phase 0.
- vga_blank  in  1  scan-out blanking, sampled in phase 0; 1 releases the VGA slot to clients.
- vga_rdata  out  DW  scan-out pixel; updated in phase 1, held for 4 clocks.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- rd_valid  in  1  read-back request.
- rd_ready  out  1  read-back request accepted this cycle.
- rd_addr  in  AW  read-back address.
- rd_rvalid  out  1  read-back data valid pulse.
- rd_rdata  out  DW  read-back data.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; synchronous, 1-cycle latency.
- addr_err  out  1  sticky flag: an out-of-range request was accepted.

## Operation
- phase: 2-bit free-running counter 0→1→2→3→0, reset to 0.
- Slot assignment:
  - Phase 0 is the VGA slot if vga_blank=0. In that slot mem_addr=vga_raddr, mem_we=0, and no client may be granted.
  - Phase 0 with vga_blank=1, and phases 1–3 always, are client slots.
- VGA capture: if phase 0 was a VGA slot, vga_rdata<=mem_rdata at the phase 1 clock edge. Otherwise vga_rdata holds its value.
- Client grant: combinational, in client slots only.
  - Only one requester valid: grant it.
  - Both valid: grant the one not granted last. The last_grant register resets to "read-back", so the writer wins the first tie.
  - wr_ready / rd_ready = grant. A request transfers when valid && ready.
  - Ready may depend on valid. Requesters must hold addr/data stable while valid and not ready.
- Write grant, in range: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data.
- Read grant, in range: mem_addr=rd_addr, mem_we=0. The next cycle asserts rd_rvalid=1 with rd_rdata=mem_rdata.
- Out of range (addr >= NPIX):
  - The request is still accepted (ready=1) and consumes the slot.
  - mem_we is forced to 0.
  - A read returns rd_rvalid=1 with rd_rdata=0 on the next cycle.
  - addr_err is set and stays 1 until reset.
- Idle cycles (no grant, no VGA slot): mem_we=0; mem_addr holds its last value.
- Reset values: phase=0, pixel_ce=0, vga_rdata=0, rd_rvalid=0, rd_rdata=0, addr_err=0, last_grant=read-back, mem_we=0, mem_addr=0, mem_wdata=0, wr_ready=0, rd_ready=0.
- Reset asserted mid-operation: an in-flight read-back is discarded and no rd_rvalid is produced. After release, phase restarts at 0.

## Timing
- pixel_ce is high in phase 3. The first pulse is the 4th clock after reset release.
- VGA latency: vga_raddr sampled at phase 0 → vga_rdata valid from phase 1 through the next phase 0. It is therefore stable when pixel_ce fires.
- Client bandwidth:
  - Guaranteed 3 accesses per 4 clocks (75 Mword/s), or 4 per 4 during blanking.
  - With both clients saturating, each receives at least 1 grant per 2 client slots.
- Write latency: the memory is updated at the clock edge ending the grant cycle.
- Read-back latency: rd_rvalid is exactly 1 cycle after the accepting cycle. Back-to-back reads give back-to-back rd_rvalid.
- vga_blank and vga_raddr are ignored outside phase 0.

## Test plan
- Scan-out: vga_blank=0, preload mem[640]=12'hABC, vga_raddr=640 → mem_addr=640 in phase 0; vga_rdata=12'hABC from phase 1 through the next phase 0; pixel_ce high only in phase 3.
- Write/read-back: write 12'h5A5 to address 1000, then read 1000 → wr_ready in a client slot, mem_we=1 exactly one cycle; rd_rvalid one cycle after acceptance with rd_rdata=12'h5A5.
- Contention: wr_valid and rd_valid held high for 40 clocks, vga_blank=0 → no grant in any phase 0; 30 total grants, 15 writes and 15 reads, alternating, writer first.
- Blanking: vga_blank=1, wr_valid held high for 8 clocks → 8 writes accepted, including both phase 0 slots; vga_rdata unchanged.
- Out of range: write to 307200, then read 307205 → both accepted; mem_we=0; rd_rdata=0 with rd_rvalid; addr_err=1 and stays 1 until reset.
- Reset mid-read: assert rst in the cycle after a read is accepted → no rd_rvalid; all outputs at reset values; after release, phase restarts at 0 and the first pixel_ce arrives on the 4th clock.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: signal bundle between the frame buffer arbiter, its three
// users (VGA scan-out, pixel writer, read-back port) and the single memory port.
interface fb_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 12
);
    // VGA scan-out
    logic          pixel_ce;
    logic [AW-1:0] vga_raddr;
    logic          vga_blank;
    logic [DW-1:0] vga_rdata;
    // Pixel writer
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    // Processor read-back
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;
    // Memory port
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    // Status
    logic          addr_err;

    // Arbiter side
    modport slave (
        output pixel_ce, vga_rdata,
        output wr_ready,
        output rd_ready, rd_rvalid, rd_rdata,
        output mem_addr, mem_we, mem_wdata,
        output addr_err,
        input  vga_raddr, vga_blank,
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr,
        input  mem_rdata
    );

    // Client / memory side
    modport master (
        input  pixel_ce, vga_rdata,
        input  wr_ready,
        input  rd_ready, rd_rvalid, rd_rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  addr_err,
        output vga_raddr, vga_blank,
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr,
        output mem_rdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: time-division arbiter for a single-port frame buffer. A 4-phase
// counter derives the 25 MHz pixel enable; phase 0 belongs to VGA scan-out
// unless blanked, every other slot is shared round-robin by writer and read-back.
module fb_arbiter #(
    parameter int NPIX = 307200,
    parameter int AW   = 19,
    parameter int DW   = 12
) (
    input  logic         CLK100MHZ,
    input  logic         rst,        // asynchronous, active-low
    fb_arbiter_if.slave  bus
);

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    // One extra bit so the range check also works when NPIX == 2**AW.
    localparam logic [AW:0] NPIX_W = (AW+1)'(NPIX);

    logic [1:0]    r_phase;
    grant_t        r_last_grant;
    logic          r_vga_fetch;     // VGA read issued last cycle, data on mem_rdata now
    logic [DW-1:0] r_vga_rdata;
    logic          r_rd_pend;       // read-back accepted last cycle
    logic          r_rd_oor;        // ...and it was out of range
    logic          r_addr_err;
    logic [AW-1:0] r_mem_addr;      // last driven address, held through idle cycles
    logic [DW-1:0] r_mem_wdata;

    logic          w_vga_slot;
    logic          w_client_slot;
    logic          w_wr_grant;
    logic          w_rd_grant;
    logic          w_wr_oor;
    logic          w_rd_oor;
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_we;
    logic [DW-1:0] w_mem_wdata;

    // Slot classification. Both slot types are qualified with rst so that no
    // grant, write strobe or address leaves the block while reset is asserted.
    assign w_vga_slot    = rst && (r_phase == 2'd0) && !bus.vga_blank;
    assign w_client_slot = rst && !((r_phase == 2'd0) && !bus.vga_blank);

    assign w_wr_oor = ({1'b0, bus.wr_addr} >= NPIX_W);
    assign w_rd_oor = ({1'b0, bus.rd_addr} >= NPIX_W);

    // Client grant: single requester wins outright, a tie goes to whoever was not served last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        if (w_client_slot) begin
            if (bus.wr_valid && bus.rd_valid) begin
                if (r_last_grant == GRANT_RD) w_wr_grant = 1'b1;
                else                          w_rd_grant = 1'b1;
            end else begin
                w_wr_grant = bus.wr_valid;
                w_rd_grant = bus.rd_valid;
            end
        end
    end

    // Memory port drive: VGA slot, then the granted client, otherwise hold address/data with we low.
    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = r_mem_wdata;
        if (w_vga_slot) begin
            w_mem_addr = bus.vga_raddr;
        end else if (w_wr_grant) begin
            w_mem_addr  = bus.wr_addr;
            w_mem_we    = !w_wr_oor;
            w_mem_wdata = bus.wr_data;
        end else if (w_rd_grant) begin
            w_mem_addr = bus.rd_addr;
        end
    end

    // Free-running pixel phase counter.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) r_phase <= 2'd0;
        else      r_phase <= r_phase + 2'd1;
    end

    // Remember which client was served last for the round-robin tie-break.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst)            r_last_grant <= GRANT_RD;
        else if (w_wr_grant) r_last_grant <= GRANT_WR;
        else if (w_rd_grant) r_last_grant <= GRANT_RD;
    end

    // Capture the scan-out pixel at the end of phase 1; during phase 1 it is bypassed straight from memory.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            r_vga_fetch <= 1'b0;
            r_vga_rdata <= '0;
        end else begin
            r_vga_fetch <= w_vga_slot;
            if (r_vga_fetch) r_vga_rdata <= bus.mem_rdata;
        end
    end

    // Read-back return pipeline: one cycle to line up with the synchronous memory.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            r_rd_pend <= 1'b0;
            r_rd_oor  <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_grant;
            r_rd_oor  <= w_rd_grant && w_rd_oor;
        end
    end

    // Sticky out-of-range flag, set by any accepted request beyond the frame.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst)
            r_addr_err <= 1'b0;
        else if ((w_wr_grant && w_wr_oor) || (w_rd_grant && w_rd_oor))
            r_addr_err <= 1'b1;
    end

    // Keep the last driven address and write data so idle cycles do not toggle the memory bus.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    assign bus.pixel_ce  = (r_phase == 2'd3);
    assign bus.vga_rdata = r_vga_fetch ? bus.mem_rdata : r_vga_rdata;
    assign bus.wr_ready  = w_wr_grant;
    assign bus.rd_ready  = w_rd_grant;
    assign bus.rd_rvalid = r_rd_pend;
    assign bus.rd_rdata  = (r_rd_pend && !r_rd_oor) ? bus.mem_rdata : '0;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.addr_err  = r_addr_err;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: self-checking bench for fb_arbiter. A cycle monitor models
// slot assignment, grants and memory drive; read-back data is predicted from a
// shadow of the frame buffer, queued on acceptance and compared on rd_rvalid.
module tb_fb_arbiter;

    localparam int NPIX = 307200;
    localparam int AW   = 19;
    localparam int DW   = 12;

    logic clk;
    logic rst;

    fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    fb_arbiter #(.NPIX(NPIX), .AW(AW), .DW(DW)) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous frame buffer model: 1-cycle read latency, out-of-range reads return 0.
    logic [DW-1:0] mem [0:NPIX-1];
    always @(posedge clk) begin
        if (bus.mem_we && int'(bus.mem_addr) < NPIX) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= (int'(bus.mem_addr) < NPIX) ? mem[bus.mem_addr] : '0;
    end

    // Cycle index since reset release; its low two bits are the expected phase.
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Shadow of frame buffer contents as the bench intends them.
    logic [DW-1:0] shadow [int];
    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        if (int'(a) >= NPIX)      return '0;
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return '0;
    endfunction

    // Monitor / model state
    logic          m_last_rd;
    logic          m_rd_pend;
    logic          m_vga_pend;
    logic          m_err;
    logic [DW-1:0] m_vga_val;
    logic [DW-1:0] m_vga_cur;
    logic [DW-1:0] m_wdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] rd_q [$];
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            we_cnt = 0;

    always @(negedge clk) begin
        logic [1:0]    ph;
        logic          vga_slot, exp_wr, exp_rd, exp_we;
        logic [DW-1:0] exp_data;
        if (!rst) begin
            check("rst_outs",
                  64'({bus.pixel_ce, bus.vga_rdata, bus.rd_rvalid, bus.rd_rdata, bus.addr_err,
                       bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wr_ready, bus.rd_ready}), 64'd0);
            m_last_rd  = 1'b1;
            m_rd_pend  = 1'b0;
            m_vga_pend = 1'b0;
            m_err      = 1'b0;
            m_vga_val  = '0;
            m_vga_cur  = '0;
            m_wdata    = '0;
            m_addr     = '0;
            rd_q.delete();
        end else begin
            ph = 2'(cyc);
            check("pixel_ce", 64'(bus.pixel_ce), 64'(ph == 2'd3));

            // read-back return for last cycle's acceptance
            check("rd_rvalid", 64'(bus.rd_rvalid), 64'(m_rd_pend));
            if (m_rd_pend && rd_q.size() > 0) begin
                exp_data = rd_q.pop_front();
                if (bus.rd_rvalid) check("rd_rdata", 64'(bus.rd_rdata), 64'(exp_data));
            end
            m_rd_pend = 1'b0;

            // scan-out pixel
            if (ph == 2'd1 && m_vga_pend) begin
                m_vga_cur  = m_vga_val;
                m_vga_pend = 1'b0;
            end
            check("vga_rdata", 64'(bus.vga_rdata), 64'(m_vga_cur));

            check("addr_err", 64'(bus.addr_err), 64'(m_err));

            // slot and grant expectation
            vga_slot = (ph == 2'd0) && !bus.vga_blank;
            exp_wr = 1'b0;
            exp_rd = 1'b0;
            if (!vga_slot) begin
                if (bus.wr_valid && bus.rd_valid) begin
                    if (m_last_rd) exp_wr = 1'b1;
                    else           exp_rd = 1'b1;
                end else begin
                    exp_wr = bus.wr_valid;
                    exp_rd = bus.rd_valid;
                end
            end
            check("grant", 64'({bus.wr_ready, bus.rd_ready}), 64'({exp_wr, exp_rd}));

            exp_we = 1'b0;
            if (vga_slot) begin
                m_addr     = bus.vga_raddr;
                m_vga_pend = 1'b1;
                m_vga_val  = shadow_rd(bus.vga_raddr);
            end else if (exp_wr) begin
                m_addr    = bus.wr_addr;
                m_wdata   = bus.wr_data;
                m_last_rd = 1'b0;
                if (int'(bus.wr_addr) < NPIX) begin
                    exp_we = 1'b1;
                    shadow[int'(bus.wr_addr)] = bus.wr_data;
                end else begin
                    m_err = 1'b1;
                end
            end else if (exp_rd) begin
                m_addr    = bus.rd_addr;
                m_last_rd = 1'b1;
                m_rd_pend = 1'b1;
                if (int'(bus.rd_addr) >= NPIX) m_err = 1'b1;
                rd_q.push_back(shadow_rd(bus.rd_addr));
            end
            check("mem_addr",  64'(bus.mem_addr),  64'(m_addr));
            check("mem_we",    64'(bus.mem_we),    64'(exp_we));
            check("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));

            if (bus.wr_valid && bus.wr_ready) wr_cnt++;
            if (bus.rd_valid && bus.rd_ready) rd_cnt++;
            if (bus.mem_we)                   we_cnt++;
        end
    end

    // Hold a write request until accepted; returns one tick after the accepting edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int  n    = 0;
        bit  done = 1'b0;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        while (!done && n < 16) begin
            @(negedge clk);
            if (bus.wr_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        bus.wr_valid = 1'b0;
        check("wr_accept", 64'(done), 64'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int  n    = 0;
        bit  done = 1'b0;
        bus.rd_addr  = a;
        bus.rd_valid = 1'b1;
        while (!done && n < 16) begin
            @(negedge clk);
            if (bus.rd_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        bus.rd_valid = 1'b0;
        check("rd_accept", 64'(done), 64'd1);
    endtask

    // Hold reset for three clocks with both clients requesting; caller releases.
    task automatic apply_reset();
        rst           = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.rd_valid  = 1'b1;
        bus.vga_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, we0, first_ce, n;

        rst           = 1'b0;
        bus.vga_raddr = '0;
        bus.vga_blank = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_valid  = 1'b0;
        bus.rd_addr   = '0;
        for (int i = 0; i < NPIX; i++) mem[i] = '0;
        mem[640]    = 12'hABC;
        shadow[640] = 12'hABC;

        // ---------------- scan-out ----------------
        apply_reset();
        bus.vga_blank = 1'b0;
        bus.vga_raddr = 19'd640;
        rst = 1'b1;
        @(negedge clk);
        check("scan_addr", 64'(bus.mem_addr), 64'd640);
        check("scan_we",   64'(bus.mem_we),   64'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("scan_px", 64'(bus.vga_rdata), 64'h0ABC);
            check("scan_ce", 64'(bus.pixel_ce), 64'(i == 3));
        end
        @(posedge clk);
        #1;

        // ---------------- write then read back ----------------
        we0 = we_cnt;
        do_write(19'd1000, 12'h5A5);
        check("wr_we_once", 64'(we_cnt - we0), 64'd1);
        do_read(19'd1000);
        @(negedge clk);
        check("rb_rvalid", 64'(bus.rd_rvalid), 64'd1);
        check("rb_rdata",  64'(bus.rd_rdata),  64'h5A5);
        @(posedge clk);
        #1;

        // ---------------- contention ----------------
        apply_reset();
        bus.vga_blank = 1'b0;
        bus.vga_raddr = 19'd2000;
        bus.wr_addr   = 19'd2000;
        bus.wr_data   = 12'h111;
        bus.rd_addr   = 19'd640;
        bus.wr_valid  = 1'b1;
        bus.rd_valid  = 1'b1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("cont_vga_nogrant", 64'({bus.wr_ready, bus.rd_ready}), 64'd0);
        @(negedge clk);
        check("cont_first_wr", 64'({bus.wr_ready, bus.rd_ready}), 64'b10);
        repeat (39) @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        check("cont_wr_cnt", 64'(wr_cnt - w0), 64'd15);
        check("cont_rd_cnt", 64'(rd_cnt - r0), 64'd15);

        // ---------------- blanking ----------------
        bus.vga_blank = 1'b1;
        while (cyc % 4 != 0) begin
            @(posedge clk);
            #1;
        end
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 19'(3000 + i);
            bus.wr_data  = 12'(12'h300 + i);
            @(negedge clk);
            check("blank_wr_ready", 64'(bus.wr_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        check("blank_wr_cnt", 64'(wr_cnt - w0), 64'd8);
        @(negedge clk);
        check("blank_vga_hold", 64'(bus.vga_rdata), 64'h111);
        @(posedge clk);
        #1;
        do_read(19'd3004);
        @(negedge clk);
        check("blank_rb", 64'({bus.rd_rvalid, bus.rd_rdata}), 64'({1'b1, 12'h304}));
        @(posedge clk);
        #1;

        // ---------------- out of range ----------------
        check("oor_err_clear", 64'(bus.addr_err), 64'd0);
        we0 = we_cnt;
        do_write(19'd307200, 12'hFFF);
        check("oor_we", 64'(we_cnt - we0), 64'd0);
        @(negedge clk);
        check("oor_err_w", 64'(bus.addr_err), 64'd1);
        @(posedge clk);
        #1;
        do_read(19'd307205);
        @(negedge clk);
        check("oor_rvalid", 64'(bus.rd_rvalid), 64'd1);
        check("oor_rdata",  64'(bus.rd_rdata),  64'd0);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("oor_err_sticky", 64'(bus.addr_err), 64'd1);
        @(posedge clk);
        #1;

        // ---------------- reset mid-read ----------------
        do_read(19'd1000);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_rvalid", 64'(bus.rd_rvalid), 64'd0);
        check("rst_err_clear", 64'(bus.addr_err), 64'd0);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        first_ce = 0;
        n = 0;
        while (first_ce == 0 && n < 8) begin
            @(negedge clk);
            n++;
            if (bus.pixel_ce) first_ce = n;
        end
        check("first_ce", 64'(first_ce), 64'd4);
        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 64'(rd_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
